// File: rtl/pa_ifu_icache_pkg.sv
// Shared types and helpers for the IFU I-cache data array.
// Holds the invalidate-sequencer state encoding and the parity and way-slice helpers.
package pa_ifu_icache_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StInv  = 2'b01,
        StDone = 2'b10
    } inv_state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned par_w(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic int unsigned way_lsb(input int unsigned way, input int unsigned data_w);
        return way * data_w;
    endfunction

endpackage

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: the enable is captured while the clock is low, so the output is glitch-free.
// Scan enable forces the clock on.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_lat;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in) begin
            clk_en_lat = clk_en_bf_latch | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & clk_en_lat;

endmodule

// File: rtl/pa_spsram_param.sv
// Behavioural single-port SRAM with active-low chip, global-write and per-bit write enables.
// Q is registered on a read and holds otherwise.
module pa_spsram_param #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32
) (
    input  logic [$clog2(DEPTH)-1:0] A,
    input  logic                     CEN,
    input  logic                     CLK,
    input  logic [WIDTH-1:0]         D,
    input  logic                     GWEN,
    output logic [WIDTH-1:0]         Q,
    input  logic [WIDTH-1:0]         WEN
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule

// File: rtl/pa_ifu_icache_data_array_nway.sv
// N-way I-cache data array: per-way gated SRAMs, optional per-byte even parity, and a
// built-in invalidate sweep that outranks refill writes, which outrank reads.
module pa_ifu_icache_data_array_nway
    import pa_ifu_icache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IDX_W      = 10,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          INV_ON_RST = 1'b0
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   cp0_yy_clk_en,
    input  logic                   cp0_ifu_icg_en,
    input  logic                   pad_yy_icg_scan_en,
    input  logic                   rd_req,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic                   rd_gnt,
    input  logic                   wr_req,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WAYS-1:0]        wr_way,
    input  logic [DATA_W-1:0]      wr_din,
    output logic                   wr_gnt,
    input  logic                   inv_req,
    output logic                   inv_busy,
    output logic                   inv_done,
    output logic [WAYS*DATA_W-1:0] rd_dout,
    output logic                   rd_dout_vld,
    output logic [WAYS-1:0]        rd_par_err
);

    localparam int unsigned DEPTH  = 2 ** IDX_W;
    localparam int unsigned PW     = par_w(DATA_W);
    localparam int unsigned SRAM_W = DATA_W + (PARITY_EN ? PW : 0);

    function automatic logic [PW-1:0] byte_par(input logic [DATA_W-1:0] v);
        for (int i = 0; i < int'(PW); i++) begin
            byte_par[i] = ^v[i*BYTE_W +: BYTE_W];
        end
    endfunction

    inv_state_e             state_q;
    logic [IDX_W-1:0]       cnt_q;
    logic                   boot_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   vld_q;
    logic [WAYS*DATA_W-1:0] hold_q;
    logic [WAYS*DATA_W-1:0] q_data;

    logic                   idle;
    logic                   inv_act;
    logic [IDX_W-1:0]       sram_a;
    logic                   gwen_n;
    logic [SRAM_W-1:0]      sram_d;
    logic [SRAM_W-1:0]      wen_n;

    assign idle    = (state_q == StIdle);
    assign inv_act = (state_q == StInv);
    assign wr_gnt  = wr_req & idle;
    assign rd_gnt  = rd_req & ~wr_req & idle;

    // boot_q fires a single sweep on the first cycle out of reset when INV_ON_RST is set.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            boot_q  <= INV_ON_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            boot_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (inv_req || boot_q) begin
                        state_q <= StInv;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StInv: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {IDX_W{1'b1}}) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            vld_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            vld_q  <= rd_gnt;
            hold_q <= rd_dout;
        end
    end

    assign inv_busy    = busy_q;
    assign inv_done    = done_q;
    assign rd_dout_vld = vld_q;
    assign rd_dout     = vld_q ? q_data : hold_q;

    assign sram_a = inv_act ? cnt_q : (wr_gnt ? wr_idx : rd_idx);
    assign gwen_n = ~(inv_act | wr_gnt);
    assign wen_n  = {SRAM_W{gwen_n}};

    if (PARITY_EN) begin : g_wpar
        assign sram_d = inv_act ? '0 : {byte_par(wr_din), wr_din};
    end else begin : g_wnopar
        assign sram_d = inv_act ? '0 : wr_din;
    end

    for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
        logic              cen_n;
        logic              gclk;
        logic [SRAM_W-1:0] q;

        assign cen_n = ~(inv_act | (wr_gnt & wr_way[w]) | rd_gnt);

        gated_clk_cell u_icg (
            .clk_in             (forever_cpuclk),
            .global_en          (cp0_yy_clk_en),
            .module_en          (cp0_ifu_icg_en),
            .local_en           (~cen_n),
            .external_en        (1'b0),
            .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
            .clk_out            (gclk)
        );

        pa_spsram_param #(
            .DEPTH (DEPTH),
            .WIDTH (SRAM_W)
        ) u_sram (
            .A    (sram_a),
            .CEN  (cen_n),
            .CLK  (gclk),
            .D    (sram_d),
            .GWEN (gwen_n),
            .Q    (q),
            .WEN  (wen_n)
        );

        assign q_data[way_lsb(w, DATA_W) +: DATA_W] = q[DATA_W-1:0];

        if (PARITY_EN) begin : g_perr
            assign rd_par_err[w] = vld_q & (|(byte_par(q[DATA_W-1:0]) ^ q[SRAM_W-1:DATA_W]));
        end else begin : g_nperr
            assign rd_par_err[w] = 1'b0;
        end
    end

endmodule

// File: tb/tb_pa_ifu_icache_data_array_nway.sv
// Directed bench for the I-cache data array: read responses go through a scoreboard queue
// checked by an independent monitor; grants and sweep timing are checked inline.
module tb_pa_ifu_icache_data_array_nway;

    localparam int unsigned WAYS   = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;

    logic                   clk = 1'b0;
    logic                   cpurst;
    logic                   cp0_yy_clk_en;
    logic                   cp0_ifu_icg_en;
    logic                   pad_yy_icg_scan_en;
    logic                   rd_req;
    logic [IDX_W-1:0]       rd_idx;
    logic                   rd_gnt;
    logic                   wr_req;
    logic [IDX_W-1:0]       wr_idx;
    logic [WAYS-1:0]        wr_way;
    logic [DATA_W-1:0]      wr_din;
    logic                   wr_gnt;
    logic                   inv_req;
    logic                   inv_busy;
    logic                   inv_done;
    logic [WAYS*DATA_W-1:0] rd_dout;
    logic                   rd_dout_vld;
    logic [WAYS-1:0]        rd_par_err;

    always #5 clk = ~clk;

    pa_ifu_icache_data_array_nway #(
        .WAYS       (WAYS),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .PARITY_EN  (1'b1),
        .INV_ON_RST (1'b1)
    ) dut (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .cp0_yy_clk_en      (cp0_yy_clk_en),
        .cp0_ifu_icg_en     (cp0_ifu_icg_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .rd_req             (rd_req),
        .rd_idx             (rd_idx),
        .rd_gnt             (rd_gnt),
        .wr_req             (wr_req),
        .wr_idx             (wr_idx),
        .wr_way             (wr_way),
        .wr_din             (wr_din),
        .wr_gnt             (wr_gnt),
        .inv_req            (inv_req),
        .inv_busy           (inv_busy),
        .inv_done           (inv_done),
        .rd_dout            (rd_dout),
        .rd_dout_vld        (rd_dout_vld),
        .rd_par_err         (rd_par_err)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  e;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [2][16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic clear_mdl();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                mdl[w][i] = 32'h0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!cpurst && rd_dout_vld) begin
            if (sb_q.size() == 0) begin
                chk("rd_dout_vld_unexpected", {63'd0, rd_dout_vld}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_dout", rd_dout, e.d);
                chk("rd_par_err", {62'd0, rd_par_err}, {62'd0, e.e});
            end
        end
    end

    // Call with reset just released (or inv_req just sampled) so the next posedge enters INV.
    task automatic sweep_check(input string tag);
        int nb = 0;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (inv_busy && !inv_done) nb++;
        end
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd16);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, inv_done}, 64'd1);
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, inv_busy, inv_done}, 64'd0);
        clear_mdl();
    endtask

    // Called at a negedge; drives one request cycle and returns at the following negedge.
    task automatic issue(input logic rd, input logic [3:0] ridx, input logic wr,
                         input logic [3:0] widx, input logic [1:0] way, input logic [31:0] din,
                         input logic exp_rg, input logic exp_wg, input logic [1:0] exp_err,
                         input string tag);
        exp_t e;
        rd_req = rd;
        rd_idx = ridx;
        wr_req = wr;
        wr_idx = widx;
        wr_way = way;
        wr_din = din;
        #2;
        chk({tag, "_rd_gnt"}, {63'd0, rd_gnt}, {63'd0, exp_rg});
        chk({tag, "_wr_gnt"}, {63'd0, wr_gnt}, {63'd0, exp_wg});
        if (exp_wg) begin
            for (int w = 0; w < 2; w++) begin
                if (way[w]) mdl[w][widx] = din;
            end
        end
        if (exp_rg) begin
            e.d = {mdl[1][ridx], mdl[0][ridx]};
            e.e = exp_err;
            sb_q.push_back(e);
        end
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;

        cpurst             = 1'b1;
        cp0_yy_clk_en      = 1'b1;
        cp0_ifu_icg_en     = 1'b0;
        pad_yy_icg_scan_en = 1'b0;
        rd_req             = 1'b0;
        rd_idx             = '0;
        wr_req             = 1'b0;
        wr_idx             = '0;
        wr_way             = '0;
        wr_din             = '0;
        inv_req            = 1'b0;
        clear_mdl();

        repeat (3) @(negedge clk);
        chk("rst_rd_gnt", {63'd0, rd_gnt}, 64'd0);
        chk("rst_wr_gnt", {63'd0, wr_gnt}, 64'd0);
        chk("rst_inv_busy", {63'd0, inv_busy}, 64'd0);
        chk("rst_inv_done", {63'd0, inv_done}, 64'd0);
        chk("rst_rd_dout_vld", {63'd0, rd_dout_vld}, 64'd0);
        chk("rst_rd_par_err", {62'd0, rd_par_err}, 64'd0);
        chk("rst_rd_dout", rd_dout, 64'd0);

        cpurst = 1'b0;
        sweep_check("boot");

        issue(1, 5, 0, 0, 2'b00, 32'h0, 1, 0, 2'b00, "rd5_after_sweep");
        issue(0, 0, 1, 3, 2'b10, 32'h12345678, 0, 1, 2'b00, "wr3_way1");
        issue(0, 0, 1, 3, 2'b01, 32'hDEADBEEF, 0, 1, 2'b00, "wr3_way0");
        issue(1, 3, 0, 0, 2'b00, 32'h0, 1, 0, 2'b00, "rd3");
        issue(0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 2'b00, "idle");
        chk("hold_rd_dout", rd_dout, 64'h12345678_DEADBEEF);
        chk("hold_vld_low", {63'd0, rd_dout_vld}, 64'd0);

        issue(1, 9, 1, 9, 2'b11, 32'hA5A50F0F, 0, 1, 2'b00, "collide");
        issue(1, 9, 0, 0, 2'b00, 32'h0, 1, 0, 2'b00, "retry_rd9");
        issue(0, 0, 1, 9, 2'b00, 32'hFFFFFFFF, 0, 1, 2'b00, "wr_noway");
        issue(1, 9, 0, 0, 2'b00, 32'h0, 1, 0, 2'b00, "rd9_unchanged");

        issue(0, 0, 1, 7, 2'b11, 32'h01020304, 0, 1, 2'b00, "wr7");
        dut.g_way[1].u_sram.mem[7] = dut.g_way[1].u_sram.mem[7] ^ 36'h1_0000_0000;
        issue(1, 7, 0, 0, 2'b00, 32'h0, 1, 0, 2'b10, "rd7_par_err");
        issue(1, 3, 0, 0, 2'b00, 32'h0, 1, 0, 2'b00, "rd3_par_ok");

        // Sweep with a held read and a second inv_req mid-sweep.
        inv_req = 1'b1;
        @(negedge clk);
        inv_req = 1'b0;
        rd_req  = 1'b1;
        rd_idx  = 4'd3;
        n       = 0;
        seen    = 1'b0;
        while (!seen && n < 40) begin
            inv_req = (n == 3);
            #2;
            chk("inv_rd_stall", {63'd0, rd_gnt}, 64'd0);
            seen = inv_done;
            @(negedge clk);
            n++;
        end
        inv_req = 1'b0;
        chk("inv_done_seen", {63'd0, seen}, 64'd1);
        chk("inv_no_restart_len", 64'(n), 64'd17);
        clear_mdl();
        issue(1, 3, 0, 0, 2'b00, 32'h0, 1, 0, 2'b00, "first_rd_after_done");

        // Reset at sweep counter 8.
        inv_req = 1'b1;
        @(negedge clk);
        inv_req = 1'b0;
        repeat (8) @(negedge clk);
        cpurst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, inv_busy}, 64'd0);
        chk("midrst_done", {63'd0, inv_done}, 64'd0);
        repeat (2) @(negedge clk);
        chk("midrst_hold_done", {63'd0, inv_done}, 64'd0);
        cpurst = 1'b0;
        sweep_check("rst_restart");
        issue(1, 7, 0, 0, 2'b00, 32'h0, 1, 0, 2'b00, "rd7_after_restart");

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
